// File: rtl/store_write_buffer_if.sv
// Store write buffer bus: core store port, load probe and memory drain port.
// Parameters follow the buffer's ADDR_W / DATA_W.
interface store_write_buffer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              cpu_wr_valid;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_wr_ready;
    logic [ADDR_W-1:0] cpu_rd_addr;
    logic              cpu_rd_hit;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              mem_wr_valid;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ready;

    modport master (
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data, cpu_rd_addr,
        output mem_wr_ready,
        input  cpu_wr_ready, cpu_rd_hit, cpu_rd_data,
        input  mem_wr_valid, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data, cpu_rd_addr,
        input  mem_wr_ready,
        output cpu_wr_ready, cpu_rd_hit, cpu_rd_data,
        output mem_wr_valid, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-store FIFO with load forwarding between core and data memory.
// Define WB_COALESCE_EN to merge a store into the youngest entry on address match.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                 CLK,
    input  logic                 Reset,
    store_write_buffer_if.slave  bus,
    output logic [CW-1:0]        count,
    output logic                 empty,
    output logic                 full
);
    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     youngest;
    logic [PW-1:0]     idx;
    logic              accept;
    logic              alloc;
    logic              coalWr;
    logic              coal;
    logic              deq;
    logic              hit;
    logic [DATA_W-1:0] fwd;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign youngest = tail - 1'b1;
    assign deq      = !empty && !Reset && bus.mem_wr_ready;

`ifdef WB_COALESCE_EN
    // The youngest entry may absorb a store unless it leaves this cycle.
    assign coal = !empty && vld[youngest]
               && (addrQ[youngest] == bus.cpu_wr_addr)
               && !(deq && (youngest == head));
`else
    assign coal = 1'b0;
`endif

    assign bus.cpu_wr_ready = !full || coal;
    assign accept = bus.cpu_wr_valid && bus.cpu_wr_ready;
    assign alloc  = accept && !coal;
    assign coalWr = accept && coal;

    assign bus.mem_wr_valid = !empty && !Reset;
    assign bus.mem_wr_addr  = addrQ[head];
    assign bus.mem_wr_data  = dataQ[head];

    // Walk oldest to youngest so the last match is the most recent store.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (vld[idx] && (addrQ[idx] == bus.cpu_rd_addr)) begin
                hit = 1'b1;
                fwd = dataQ[idx];
            end
        end
    end

    assign bus.cpu_rd_hit  = hit && !Reset;
    assign bus.cpu_rd_data = (hit && !Reset) ? fwd : '0;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (alloc) begin
                addrQ[tail] <= bus.cpu_wr_addr;
                dataQ[tail] <= bus.cpu_wr_data;
                vld[tail]   <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (coalWr) begin
                dataQ[youngest] <= bus.cpu_wr_data;
            end
            if (deq) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            unique case ({alloc, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-store buffer between the core's store path and the data memory.
- Accepts stores from the core in one cycle and queues them in a DEPTH-entry FIFO. Drains them to memory over a valid/ready handshake, so a slow or stalled memory does not stall the core's stores.
- Loads probe the buffer: a pending store to the same word is forwarded, so the core always sees its own most recent write.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of two and at least 2.
- ADDR_W, 6, word address width; matches the 64-entry data memory.
- DATA_W, 32, store data width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- cpu_wr_valid  in  1  core presents a store.
- cpu_wr_addr  in  ADDR_W  store address.
- cpu_wr_data  in  DATA_W  store data.
- cpu_wr_ready  out  1  buffer can accept a store this cycle.
- cpu_rd_addr  in  ADDR_W  load probe address (combinational lookup).
- cpu_rd_hit  out  1  a pending store matches cpu_rd_addr.
- cpu_rd_data  out  DATA_W  data of the youngest matching pending store; 0 when there is no hit.
- mem_wr_valid  out  1  head entry is presented to memory.
- mem_wr_addr  out  ADDR_W  head entry address.
- mem_wr_data  out  DATA_W  head entry data.
- mem_wr_ready  in  1  memory accepts the head entry this cycle.
- count  out  log2(DEPTH)+1  number of occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset:
  - head, tail and count are 0; all entry valid bits are cleared.
  - Outputs: mem_wr_valid=0, cpu_rd_hit=0, cpu_rd_data=0, empty=1, full=0, cpu_wr_ready=1.
  - Reset asserted mid-operation discards all queued stores; no memory write is issued in the reset cycle or after it.
- Enqueue: on cpu_wr_valid & cpu_wr_ready, write {addr,data} at tail, set tail=tail+1 (mod DEPTH) and set the entry valid.
- cpu_wr_ready = !full. It does not depend on mem_wr_ready in the same cycle, so there is no combinational path from memory to core.
- Dequeue: on mem_wr_valid & mem_wr_ready, clear the head entry valid and set head=head+1 (mod DEPTH).
- mem_wr_valid = !empty. mem_wr_addr/mem_wr_data are driven from the head entry storage.
- When mem_wr_valid=1 and mem_wr_ready=0, mem_wr_addr and mem_wr_data hold stable until the transfer completes.
- Latency: a store accepted in cycle N into an empty buffer appears on mem_wr_* in cycle N+1. The buffer adds no bubbles between back-to-back drains.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. Allowed at any occupancy below DEPTH; at DEPTH the enqueue is refused because cpu_wr_ready=0.
- count: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Pointer wrap: head and tail wrap modulo DEPTH. full/empty are derived from count, not from pointer equality.
- Forwarding:
  - Compare cpu_rd_addr against all valid entries.
  - On multiple matches, the youngest entry (closest to tail-1) wins.
  - A store being enqueued in the same cycle is not forwarded; it becomes visible the following cycle.
  - An entry dequeued in the current cycle still forwards in that cycle.
- Ordering: stores reach memory in strict acceptance order.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: a store whose address matches the youngest valid entry overwrites that entry's data in place, without allocating a new entry or changing count, provided:
  - the buffer is non-empty, and
  - that entry is not simultaneously being dequeued (i.e. it is not the head with mem_wr_ready=1).
- When coalescing is possible, cpu_wr_ready=1 even if full.
- Not defined: every accepted store allocates a new entry; cpu_wr_ready = !full strictly.

Test Plan:
- Reset, then store addr 0x05 data 0xDEADBEEF with mem_wr_ready=1 -> mem_wr_valid=1, addr 0x05, data 0xDEADBEEF in the next cycle; empty=1 one cycle later.
- Hold mem_wr_ready=0 and issue 4 stores (addr 1..4) -> count=4, full=1, cpu_wr_ready=0; a 5th store is refused; mem_wr_addr stays 1 throughout the stall.
- At full, assert mem_wr_ready=1 for 4 cycles -> memory sees addr 1,2,3,4 in order; empty=1 afterwards; tail and head have wrapped to 0.
- Stall memory, store addr 0x10 data 0x11, then addr 0x10 data 0x22; probe cpu_rd_addr=0x10 -> hit=1, data=0x22. Probe 0x11 -> hit=0, data=0.
- With count=2, assert enqueue and dequeue in the same cycle -> count stays 2; the drained entry and the new entry are both correct. Assert Reset with 3 entries queued -> count=0 and mem_wr_valid=0 the next cycle.
- With WB_COALESCE_EN defined, full buffer whose youngest entry is addr 0x08 and mem_wr_ready=0: store addr 0x08 data 0x99 -> accepted, count stays 4, and 0x99 is written to memory when that entry drains. Without the macro, the same store is refused.
